// File: rtl/shifter_spi_master_if.sv
// Request/response handshake between the execute stage and shifter_spi_master.
// The master modport is the processor side; the slave modport is the SPI master block.
interface shifter_spi_master_if #(
   parameter int DATA_WIDTH   = 8,
   parameter int OPCODE_WIDTH = 2
);
   localparam int SHAMT_W = $clog2(DATA_WIDTH);

   logic                    req_valid;
   logic                    req_ready;
   logic [OPCODE_WIDTH-1:0] op_code;
   logic [DATA_WIDTH-1:0]   operand;
   logic [SHAMT_W-1:0]      shift_amount;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [DATA_WIDTH-1:0]   rsp_data;

   modport master (
      output req_valid, op_code, operand, shift_amount, rsp_ready,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, op_code, operand, shift_amount, rsp_ready,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/shifter_spi_master.sv
// SPI master issuing one shift request to the barrel-shifter slave and returning its result.
// Optional WAIT timeout and o_timeout port: define SHIFTER_MASTER_TIMEOUT_EN.
module shifter_spi_master #(
   parameter int DATA_WIDTH     = 8,
   parameter int OPCODE_WIDTH   = 2,
   parameter int NSS_WIDTH      = 1,
   parameter int TARGET         = 0,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   shifter_spi_master_if.slave  bus,
   output logic                 o_busy,
   output logic [NSS_WIDTH-1:0] o_nss,
   output logic                 o_mosi,
   input  logic                 i_miso
`ifdef SHIFTER_MASTER_TIMEOUT_EN
   ,
   output logic                 o_timeout
`endif
);
   localparam int SHAMT_W = $clog2(DATA_WIDTH);
   localparam int P       = OPCODE_WIDTH + DATA_WIDTH + SHAMT_W;
   localparam int CNT_W   = $clog2(P);
   localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(P - 1);
   localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_TX, S_WAIT, S_RX, S_DONE} state_t;

   state_t                state, state_next;
   logic [P-1:0]          tx_sr;
   logic [DATA_WIDTH-2:0] rx_sr;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic [CNT_W-1:0]      bit_cnt;
   logic                  tx_last, rx_last, timed_out;

   assign tx_last      = (bit_cnt == TX_LAST);
   assign rx_last      = (bit_cnt == RX_LAST);
   assign bus.rsp_data = rsp_data;

`ifdef SHIFTER_MASTER_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WAIT_W-1:0] wait_cnt;
   logic              timeout_q;

   // Fires on the TIMEOUT_CYCLES-th WAIT cycle if the slave still has not answered.
   assign timed_out = (state == S_WAIT) && !i_miso &&
                      (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
   assign o_timeout = timeout_q;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         wait_cnt <= (state == S_WAIT) ? wait_cnt + WAIT_W'(1) : '0;
         if (timed_out)
            timeout_q <= 1'b1;
         else if (state == S_DONE && bus.rsp_ready)
            timeout_q <= 1'b0;
      end
   end
`else
   assign timed_out = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   // NOTE: every output and next-state gets a default first, so no path through the case infers a latch.
   always_comb begin
      state_next    = state;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      o_busy        = 1'b1;
      o_mosi        = 1'b0;
      o_nss         = '1;
      case (state)
         S_IDLE: begin
            bus.req_ready = 1'b1;
            o_busy        = 1'b0;
            if (bus.req_valid) state_next = S_START;
         end
         S_START: begin
            o_nss[TARGET] = 1'b0;
            o_mosi        = 1'b1;
            state_next    = S_TX;
         end
         S_TX: begin
            o_nss[TARGET] = 1'b0;
            o_mosi        = tx_sr[0];
            if (tx_last) state_next = S_WAIT;
         end
         S_WAIT: begin
            o_nss[TARGET] = 1'b0;
            if (i_miso)         state_next = S_RX;
            else if (timed_out) state_next = S_DONE;
         end
         S_RX: begin
            o_nss[TARGET] = 1'b0;
            if (rx_last) state_next = S_DONE;
         end
         S_DONE: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         tx_sr    <= '0;
         rx_sr    <= '0;
         rsp_data <= '0;
         bit_cnt  <= '0;
      end else begin
         case (state)
            S_IDLE:
               if (bus.req_valid) tx_sr <= {bus.shift_amount, bus.operand, bus.op_code};
            S_TX: begin
               tx_sr   <= tx_sr >> 1;
               bit_cnt <= tx_last ? '0 : bit_cnt + CNT_W'(1);
            end
            S_WAIT:
               if (timed_out) rsp_data <= '0;
            S_RX: begin
               // Result arrives LSB first: shift in at the top, the final bit completes the word.
               rx_sr   <= {i_miso, rx_sr[DATA_WIDTH-2:1]};
               bit_cnt <= rx_last ? '0 : bit_cnt + CNT_W'(1);
               if (rx_last) rsp_data <= {i_miso, rx_sr};
            end
            default: ;
         endcase
      end
   end
endmodule
